dat_proc_unit_nbit: RTL and testbench

DAT_PROC_UNIT_NBIT -- requirements
Module: dat_proc_unit_nbit

---
 rtl/dat_proc_pkg.sv | 38 +++
 rtl/func_unit_nbit.sv | 73 +++++++
 rtl/dat_proc_unit_nbit.sv | 165 ++++++++++++++++
 tb/tb_dat_proc_unit_nbit.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dat_proc_pkg.sv
// Shared definitions for the N-bit datapath unit: function-select codes,
// shifter codes and the control FSM state type.
package dat_proc_pkg;

  localparam logic [3:0] G_A     = 4'b0000;
  localparam logic [3:0] G_INC   = 4'b0001;
  localparam logic [3:0] G_ADD   = 4'b0010;
  localparam logic [3:0] G_ADDC  = 4'b0011;
  localparam logic [3:0] G_ADDNB = 4'b0100;
  localparam logic [3:0] G_SUB   = 4'b0101;
  localparam logic [3:0] G_DEC   = 4'b0110;
  localparam logic [3:0] G_A2    = 4'b0111;
  localparam logic [3:0] G_AND   = 4'b1000;
  localparam logic [3:0] G_OR    = 4'b1010;
  localparam logic [3:0] G_XOR   = 4'b1100;
  localparam logic [3:0] G_NOT   = 4'b1110;
  localparam logic [3:0] G_MUL   = 4'b1111;

  localparam logic [1:0] H_PASS  = 2'b00;
  localparam logic [1:0] H_SHR   = 2'b01;
  localparam logic [1:0] H_SHL   = 2'b10;
  localparam logic [1:0] H_ZERO  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL,
    WB
  } state_t;

  // Only a multiply whose result actually reaches write-back needs the
  // iterative multiplier; everything else takes the single-cycle path.
  function automatic logic is_mul_op(input logic md, input logic mf,
                                     input logic [3:0] g);
    return !md && !mf && (g == G_MUL);
  endfunction

endpackage

// File: rtl/func_unit_nbit.sv
// Combinational ALU plus shifter. Arithmetic runs WIDTH+1 bits wide so the
// carry falls out of the top bit; C/V are cleared when the shifter is chosen.
module func_unit_nbit
  import dat_proc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       g_sel_i,
  input  logic [1:0]       h_sel_i,
  input  logic             mf_sel_i,
  output logic [WIDTH-1:0] f_o,
  output logic             c_o,
  output logic             v_o
);

  logic [WIDTH-1:0] b_op;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] g_res;
  logic             g_c;
  logic             g_v;
  logic [WIDTH-1:0] h_res;

  // Every arithmetic code is A + (0 | B | ~B | all-ones) + carry-in.
  always_comb begin
    b_op = '0;
    cin  = 1'b0;
    case (g_sel_i)
      G_A, G_A2, G_MUL: b_op = '0;
      G_INC:   cin = 1'b1;
      G_ADD:   b_op = b_i;
      G_ADDC:  begin b_op = b_i;  cin = 1'b1; end
      G_ADDNB: b_op = ~b_i;
      G_SUB:   begin b_op = ~b_i; cin = 1'b1; end
      G_DEC:   b_op = '1;
      default: b_op = '0;
    endcase
  end

  assign sum = {1'b0, a_i} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    g_res = sum[WIDTH-1:0];
    g_c   = sum[WIDTH];
    // carry into the MSB is recovered from the MSB sum bit and its operands
    g_v   = a_i[WIDTH-1] ^ b_op[WIDTH-1] ^ sum[WIDTH-1] ^ sum[WIDTH];
    case (g_sel_i)
      G_AND:   begin g_res = a_i & b_i; g_c = 1'b0; g_v = 1'b0; end
      G_OR:    begin g_res = a_i | b_i; g_c = 1'b0; g_v = 1'b0; end
      G_XOR:   begin g_res = a_i ^ b_i; g_c = 1'b0; g_v = 1'b0; end
      G_NOT:   begin g_res = ~a_i;      g_c = 1'b0; g_v = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    h_res = '0;
    case (h_sel_i)
      H_PASS:  h_res = b_i;
      H_SHR:   h_res = {1'b0, b_i[WIDTH-1:1]};
      H_SHL:   h_res = {b_i[WIDTH-2:0], 1'b0};
      H_ZERO:  h_res = '0;
      default: h_res = '0;
    endcase
  end

  assign f_o = mf_sel_i ? h_res : g_res;
  assign c_o = mf_sel_i ? 1'b0  : g_c;
  assign v_o = mf_sel_i ? 1'b0  : g_v;

endmodule

// File: rtl/dat_proc_unit_nbit.sv
// N-bit datapath: register file, bus muxes, operation FSM and a shift-add
// multiplier around the combinational function unit.
module dat_proc_unit_nbit
  import dat_proc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREG  = 8,
  localparam int RSEL = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             load_enable,
  input  logic [RSEL-1:0]  A_select,
  input  logic [RSEL-1:0]  B_select,
  input  logic [RSEL-1:0]  D_select,
  input  logic [3:0]       G_select,
  input  logic [1:0]       H_select,
  input  logic             MB_select,
  input  logic             MF_select,
  input  logic             MD_select,
  input  logic [WIDTH-1:0] constant_input,
  input  logic [WIDTH-1:0] data_input,
  output logic [WIDTH-1:0] bus_A,
  output logic [WIDTH-1:0] bus_B,
  output logic             V,
  output logic             C,
  output logic             N,
  output logic             Z,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] STEPS = CW'(WIDTH);

  state_t             state_q;
  logic               ready_q;
  logic               done_q;
  logic               v_q, c_q, n_q, z_q;
  logic [WIDTH-1:0]   rf_q [NREG];

  logic               accept;
  logic [WIDTH-1:0]   a_q, b_q, data_q;
  logic [RSEL-1:0]    d_sel_q;
  logic [3:0]         g_q;
  logic [1:0]         h_q;
  logic               mf_q, md_q, load_q;

  logic [WIDTH-1:0]   res_q;
  logic               res_c_q, res_v_q;

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  logic [WIDTH-1:0]   fu_f;
  logic               fu_c, fu_v;

  assign bus_A  = rf_q[A_select];
  assign bus_B  = MB_select ? constant_input : rf_q[B_select];
  assign accept = (state_q == IDLE) && op_valid;
  assign acc_d  = mplier_q[0] ? acc_q + mcand_q : acc_q;

  func_unit_nbit #(.WIDTH(WIDTH)) u_fu (
    .a_i      (a_q),
    .b_i      (b_q),
    .g_sel_i  (g_q),
    .h_sel_i  (h_q),
    .mf_sel_i (mf_q),
    .f_o      (fu_f),
    .c_o      (fu_c),
    .v_o      (fu_v)
  );

  // Capture stage: operands are snapshotted at acceptance, so a write-back
  // to a source register cannot disturb an operation already in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q     <= bus_A;
      b_q     <= bus_B;
      data_q  <= data_input;
      d_sel_q <= D_select;
      g_q     <= G_select;
      h_q     <= H_select;
      mf_q    <= MF_select;
      md_q    <= MD_select;
      load_q  <= load_enable;
    end
    // Result stage: one EXEC cycle, or the extra MUL cycle after the last step
    if (state_q == EXEC) begin
      res_q   <= fu_f;
      res_c_q <= fu_c;
      res_v_q <= fu_v;
    end else if (state_q == MUL && cnt_q == STEPS) begin
      res_q   <= acc_q[WIDTH-1:0];
      res_c_q <= |acc_q[2*WIDTH-1:WIDTH];
      res_v_q <= |acc_q[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      v_q      <= 1'b0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (op_valid) begin
            ready_q  <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, bus_A};
            mplier_q <= bus_B;
            cnt_q    <= '0;
            state_q  <= is_mul_op(MD_select, MF_select, G_select) ? MUL : EXEC;
          end
        end
        EXEC: state_q <= WB;
        MUL: begin
          if (cnt_q != STEPS) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
          end else begin
            state_q  <= WB;
          end
        end
        // Write-back stage: commit the result, then pulse done while idle again
        WB: begin
          if (load_q) rf_q[d_sel_q] <= md_q ? data_q : res_q;
          if (!md_q) begin
            z_q <= (res_q == '0);
            n_q <= res_q[WIDTH-1];
            c_q <= res_c_q;
            v_q <= res_v_q;
          end
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign op_ready = ready_q;
  assign done     = done_q;
  assign V        = v_q;
  assign C        = c_q;
  assign N        = n_q;
  assign Z        = z_q;

endmodule

// File: tb/tb_dat_proc_unit_nbit.sv
// Self-checking bench for dat_proc_unit_nbit (WIDTH=8, NREG=8): directed
// cases plus randomized operations against an arithmetic reference model.
`timescale 1ns/1ps
module tb_dat_proc_unit_nbit;

  localparam int W  = 8;
  localparam int NR = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid;
  logic       op_ready;
  logic       load_enable;
  logic [2:0] A_select, B_select, D_select;
  logic [3:0] G_select;
  logic [1:0] H_select;
  logic       MB_select, MF_select, MD_select;
  logic [7:0] constant_input, data_input;
  logic [7:0] bus_A, bus_B;
  logic       V, C, N, Z;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_rf [NR];
  logic       m_v, m_c, m_n, m_z;

  always #10 clk = ~clk;

  dat_proc_unit_nbit #(.WIDTH(W), .NREG(NR)) dut (
    .clk            (clk),
    .reset          (reset),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .load_enable    (load_enable),
    .A_select       (A_select),
    .B_select       (B_select),
    .D_select       (D_select),
    .G_select       (G_select),
    .H_select       (H_select),
    .MB_select      (MB_select),
    .MF_select      (MF_select),
    .MD_select      (MD_select),
    .constant_input (constant_input),
    .data_input     (data_input),
    .bus_A          (bus_A),
    .bus_B          (bus_B),
    .V              (V),
    .C              (C),
    .N              (N),
    .Z              (Z),
    .done           (done)
  );

  // Reference ALU from the arithmetic meaning of each code: returns {C,V,F}.
  function automatic logic [9:0] ref_g(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] g);
    int ua, ub, sa, sb, full, sfull;
    logic [7:0] f;
    logic c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    full = ua; sfull = sa;
    case (g)
      4'h1: begin full = ua + 1;         sfull = sa + 1;      end
      4'h2: begin full = ua + ub;        sfull = sa + sb;     end
      4'h3: begin full = ua + ub + 1;    sfull = sa + sb + 1; end
      4'h4: begin full = ua + 255 - ub;  sfull = sa - sb - 1; end
      4'h5: begin full = ua + 256 - ub;  sfull = sa - sb;     end
      4'h6: begin full = ua + 255;       sfull = sa - 1;      end
      default: ;
    endcase
    f = full[7:0];
    c = (full > 255);
    v = (sfull > 127) || (sfull < -128);
    case (g)
      4'h8: begin f = a & b; c = 1'b0; v = 1'b0; end
      4'hA: begin f = a | b; c = 1'b0; v = 1'b0; end
      4'hC: begin f = a ^ b; c = 1'b0; v = 1'b0; end
      4'hE: begin f = ~a;    c = 1'b0; v = 1'b0; end
      default: ;
    endcase
    return {c, v, f};
  endfunction

  function automatic logic [7:0] ref_h(input logic [7:0] b, input logic [1:0] h);
    case (h)
      2'd0:    return b;
      2'd1:    return b >> 1;
      2'd2:    return b << 1;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) m_rf[i] = 8'h00;
    {m_v, m_c, m_n, m_z} = 4'b0000;
  endtask

  task automatic do_op(input logic [2:0] as, input logic [2:0] bs, input logic [2:0] ds,
                       input logic [3:0] g, input logic [1:0] h, input logic mb,
                       input logic mf, input logic md, input logic ld,
                       input logic [7:0] k, input logic [7:0] din, input string nm);
    logic [7:0]  a, b, f;
    logic [9:0]  r;
    logic [15:0] p;
    logic        c, v;
    int          exp_lat, lat;
    @(negedge clk);
    A_select = as; B_select = bs; D_select = ds; G_select = g; H_select = h;
    MB_select = mb; MF_select = mf; MD_select = md; load_enable = ld;
    constant_input = k; data_input = din; op_valid = 1'b1;
    #1;
    a = m_rf[as];
    b = mb ? k : m_rf[bs];
    n_checks++;
    if (op_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s op_ready before accept: got %b want 1", nm, op_ready);
    end
    n_checks++;
    if (bus_A !== a) begin
      n_fail++; $display("FAIL %s bus_A: got %h want %h", nm, bus_A, a);
    end
    n_checks++;
    if (bus_B !== b) begin
      n_fail++; $display("FAIL %s bus_B: got %h want %h", nm, bus_B, b);
    end
    @(posedge clk); #1;
    // Inputs wander while busy; none of it may matter.
    op_valid = 1'b0;
    A_select = 3'($urandom); B_select = 3'($urandom); D_select = 3'($urandom);
    G_select = 4'($urandom); H_select = 2'($urandom);
    MB_select = 1'($urandom); MF_select = 1'($urandom); MD_select = 1'($urandom);
    load_enable = 1'($urandom); constant_input = 8'($urandom); data_input = 8'($urandom);

    c = 1'b0; v = 1'b0;
    if (md) begin
      f = din;
    end else if (mf) begin
      f = ref_h(b, h);
    end else if (g == 4'hF) begin
      p = 16'(a) * 16'(b);
      f = p[7:0];
      c = (p[15:8] != 8'h00);
      v = c;
    end else begin
      r = ref_g(a, b, g);
      f = r[7:0]; v = r[8]; c = r[9];
    end
    exp_lat = (!md && !mf && g == 4'hF) ? W + 2 : 2;

    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++; $display("FAIL %s done latency: got %0d want %0d (0 = timeout)", nm, lat, exp_lat);
    end
    n_checks++;
    if (op_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s op_ready in done cycle: got %b want 1", nm, op_ready);
    end

    if (!md) begin
      m_z = (f == 8'h00);
      m_n = f[7];
      m_c = c;
      m_v = v;
    end
    if (ld) m_rf[ds] = f;

    n_checks++;
    if ({V, C, N, Z} !== {m_v, m_c, m_n, m_z}) begin
      n_fail++; $display("FAIL %s flags VCNZ: got %b%b%b%b want %b%b%b%b", nm,
                         V, C, N, Z, m_v, m_c, m_n, m_z);
    end
    A_select = ds;
    #1;
    n_checks++;
    if (bus_A !== m_rf[ds]) begin
      n_fail++; $display("FAIL %s R%0d: got %h want %h", nm, ds, bus_A, m_rf[ds]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    op_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    n_checks++;
    if (op_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset ready/done: got %b/%b want 1/0", op_ready, done);
    end
    n_checks++;
    if ({V, C, N, Z} !== 4'b0000) begin
      n_fail++; $display("FAIL reset flags VCNZ: got %b%b%b%b want 0000", V, C, N, Z);
    end
    for (int i = 0; i < NR; i++) begin
      A_select = 3'(i);
      #1;
      n_checks++;
      if (bus_A !== 8'h00) begin
        n_fail++; $display("FAIL reset R%0d: got %h want 00", i, bus_A);
      end
    end
  endtask

  task automatic test_load();
    do_op(3'd0, 3'd0, 3'd3, 4'h2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hA5, "load_R3");
  endtask

  task automatic test_add_overflow();
    do_op(3'd0, 3'd0, 3'd1, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h7F, "load_R1");
    do_op(3'd0, 3'd0, 3'd2, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h01, "load_R2");
    do_op(3'd1, 3'd2, 3'd0, 4'h2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, "add_7F_01");
  endtask

  task automatic test_inc_sub();
    do_op(3'd0, 3'd0, 3'd1, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, "load_R1_FF");
    do_op(3'd1, 3'd0, 3'd4, 4'h1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, "inc_FF");
    do_op(3'd0, 3'd0, 3'd1, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, "load_R1_00");
    do_op(3'd1, 3'd0, 3'd5, 4'h5, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, "sub_00_k01");
    do_op(3'd5, 3'd0, 3'd6, 4'h6, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, "dec_noload");
  endtask

  task automatic test_mul();
    do_op(3'd0, 3'd0, 3'd1, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h0F, "load_0F");
    do_op(3'd0, 3'd0, 3'd2, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h11, "load_11");
    do_op(3'd1, 3'd2, 3'd6, 4'hF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, "mul_0F_11");
    do_op(3'd0, 3'd0, 3'd1, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h10, "load_10");
    do_op(3'd1, 3'd1, 3'd7, 4'hF, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 8'h00, "mul_10_10");
  endtask

  task automatic test_shift();
    do_op(3'd0, 3'd6, 3'd4, 4'h2, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, "shr");
    do_op(3'd0, 3'd0, 3'd4, 4'h2, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC3, 8'h00, "shl");
    do_op(3'd0, 3'd0, 3'd4, 4'h2, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC3, 8'h00, "hzero");
    do_op(3'd0, 3'd0, 3'd3, 4'hF, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81, 8'h00, "hpass_g15");
  endtask

  task automatic test_alias();
    do_op(3'd0, 3'd0, 3'd0, 4'h2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, "alias_add");
    do_op(3'd6, 3'd6, 3'd6, 4'hF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, "alias_mul");
  endtask

  task automatic test_back_to_back();
    do_op(3'd2, 3'd3, 3'd5, 4'h8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, "b2b_and");
    do_op(3'd5, 3'd3, 3'd5, 4'hA, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, "b2b_or");
    do_op(3'd5, 3'd0, 3'd5, 4'hC, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 8'h00, "b2b_xor");
    do_op(3'd5, 3'd0, 3'd2, 4'hE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, "b2b_not");
  endtask

  task automatic test_random();
    logic [3:0] g;
    for (int n = 0; n < 40; n++) begin
      g = 4'($urandom);
      if ($urandom_range(0, 3) == 0) g = 4'hF;
      do_op(3'($urandom), 3'($urandom), 3'($urandom), g, 2'($urandom),
            1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), "random");
    end
  endtask

  task automatic test_reset_during_mul();
    int hits;
    @(negedge clk);
    A_select = 3'd1; B_select = 3'd2; D_select = 3'd3; G_select = 4'hF; H_select = 2'd0;
    MB_select = 1'b1; MF_select = 1'b0; MD_select = 1'b0; load_enable = 1'b1;
    constant_input = 8'h03; data_input = 8'h00; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    model_clear();
    n_checks++;
    if (op_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort ready/done: got %b/%b want 1/0", op_ready, done);
    end
    @(negedge clk);
    reset = 1'b0;
    hits = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) hits++;
    end
    n_checks++;
    if (hits != 0) begin
      n_fail++; $display("FAIL abort done pulses: got %0d want 0", hits);
    end
    for (int i = 0; i < NR; i++) begin
      A_select = 3'(i);
      #1;
      n_checks++;
      if (bus_A !== 8'h00) begin
        n_fail++; $display("FAIL abort R%0d: got %h want 00", i, bus_A);
      end
    end
    n_checks++;
    if ({V, C, N, Z} !== 4'b0000) begin
      n_fail++; $display("FAIL abort flags VCNZ: got %b%b%b%b want 0000", V, C, N, Z);
    end
  endtask

  task automatic test_reset_priority();
    int hits;
    do_op(3'd0, 3'd0, 3'd4, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h3C, "pre_prio");
    @(negedge clk);
    D_select = 3'd2; MD_select = 1'b1; load_enable = 1'b1; data_input = 8'h55;
    MF_select = 1'b0; G_select = 4'h0;
    op_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    op_valid = 1'b0;
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) hits++;
    end
    n_checks++;
    if (hits != 0 || op_ready !== 1'b1) begin
      n_fail++; $display("FAIL prio done/ready: got %0d/%b want 0/1", hits, op_ready);
    end
    A_select = 3'd2;
    #1;
    n_checks++;
    if (bus_A !== 8'h00) begin
      n_fail++; $display("FAIL prio R2: got %h want 00", bus_A);
    end
    A_select = 3'd4;
    #1;
    n_checks++;
    if (bus_A !== 8'h00) begin
      n_fail++; $display("FAIL prio R4: got %h want 00", bus_A);
    end
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; load_enable = 1'b0;
    A_select = '0; B_select = '0; D_select = '0; G_select = '0; H_select = '0;
    MB_select = 1'b0; MF_select = 1'b0; MD_select = 1'b0;
    constant_input = '0; data_input = '0;
    model_clear();

    test_reset();
    test_load();
    test_add_overflow();
    test_inc_sub();
    test_mul();
    test_shift();
    test_alias();
    test_back_to_back();
    test_random();
    test_reset_during_mul();
    test_reset_priority();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
